csr_file: RTL

CSR_FILE -- requirements
Module: csr_file

---
 rtl/csr_file.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file: status/trap CSRs, 64-bit cycle/instret counters,
// and a registered fetch redirect for trap entry and mret.
module csr_file #(
  parameter logic [31:0] MHARTID   = 32'h0,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [11:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        retire_i,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_tval_i,
  input  logic        mret_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        mie_global_o
);

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        trap_acc, mret_acc, wr_acc;
  logic [31:0] cause_idx, trap_target;

  assign trap_acc = i_en & trap_i;
  assign mret_acc = i_en & mret_i & ~trap_i;
  assign wr_acc   = i_en & csr_we_i & ~trap_i & ~mret_i;

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  assign cause_idx   = {1'b0, trap_cause_i[30:0]};
  assign trap_target = (mtvec_q & 32'hFFFF_FFFC) +
                       ((mtvec_q[0] & trap_cause_i[31]) ? (cause_idx << 2) : 32'h0);

  always_comb begin
    mstatus_mie_d    = mstatus_mie_q;
    mstatus_mpie_d   = mstatus_mpie_q;
    mie_d            = mie_q;
    mtvec_d          = mtvec_q;
    mscratch_d       = mscratch_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    mcycle_d         = mcycle_q + 64'd1;
    minstret_d       = minstret_q + {63'd0, i_en & retire_i};

    if (trap_acc) begin
      mepc_d           = trap_pc_i & 32'hFFFF_FFFC;
      mcause_d         = trap_cause_i;
      mtval_d          = trap_tval_i;
      mstatus_mpie_d   = mstatus_mie_q;
      mstatus_mie_d    = 1'b0;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = trap_target;
    end else if (mret_acc) begin
      mstatus_mie_d    = mstatus_mpie_q;
      mstatus_mpie_d   = 1'b1;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = mepc_q;
    end else if (wr_acc) begin
      case (csr_waddr_i)
        12'h300: begin
          mstatus_mie_d  = csr_wdata_i[3];
          mstatus_mpie_d = csr_wdata_i[7];
        end
        12'h304: mie_d      = csr_wdata_i;
        12'h305: mtvec_d    = csr_wdata_i & 32'hFFFF_FFFD;
        12'h340: mscratch_d = csr_wdata_i;
        12'h341: mepc_d     = csr_wdata_i & 32'hFFFF_FFFC;
        12'h342: mcause_d   = csr_wdata_i;
        12'h343: mtval_d    = csr_wdata_i;
        12'hB00: mcycle_d   = {mcycle_q[63:32], csr_wdata_i};
        12'hB80: mcycle_d   = {csr_wdata_i, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], csr_wdata_i};
        12'hB82: minstret_d = {csr_wdata_i, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mstatus_mie_q    <= 1'b0;
      mstatus_mpie_q   <= 1'b0;
      mie_q            <= '0;
      mtvec_q          <= MTVEC_RST;
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      mcycle_q         <= '0;
      minstret_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      mstatus_mie_q    <= mstatus_mie_d;
      mstatus_mpie_q   <= mstatus_mpie_d;
      mie_q            <= mie_d;
      mtvec_q          <= mtvec_d;
      mscratch_q       <= mscratch_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      mcycle_q         <= mcycle_d;
      minstret_q       <= minstret_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  always_comb begin
    csr_rdata_o   = '0;
    csr_illegal_o = 1'b0;
    case (csr_raddr_i)
      12'h300: csr_rdata_o = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      12'h301: csr_rdata_o = 32'h4000_0100;
      12'h304: csr_rdata_o = mie_q;
      12'h305: csr_rdata_o = mtvec_q;
      12'h340: csr_rdata_o = mscratch_q;
      12'h341: csr_rdata_o = mepc_q;
      12'h342: csr_rdata_o = mcause_q;
      12'h343: csr_rdata_o = mtval_q;
      12'h344, 12'hF11, 12'hF12, 12'hF13: csr_rdata_o = '0;
      12'hB00, 12'hC00: csr_rdata_o = mcycle_q[31:0];
      12'hB80, 12'hC80: csr_rdata_o = mcycle_q[63:32];
      12'hB02, 12'hC02: csr_rdata_o = minstret_q[31:0];
      12'hB82, 12'hC82: csr_rdata_o = minstret_q[63:32];
      12'hF14: csr_rdata_o = MHARTID;
      default: csr_illegal_o = 1'b1;
    endcase
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign mie_global_o     = mstatus_mie_q;

endmodule
